// File: rtl/decomp_frontend_if.sv
// AXI-Stream link carrying 256-bit beats into and out of the decompression frontend.
interface decomp_frontend_if #(
   parameter int DATA_W = 256
);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tvalid;
   logic                tlast;
   logic                tready;

   modport master (output tdata, tkeep, tvalid, tlast, input  tready);
   modport slave  (input  tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/decomp_frontend.sv
// Receive-side decompressor: forwards headers and unmarked packets verbatim and expands
// bitmap-coded 8-word groups from the payload bitstream back into full 256-bit beats.

// One output word: pulls a 0/8/16/32-bit field out of the current group window.
module decomp_lane (
   input  logic [271:0] win,
   input  logic [8:0]   off,
   input  logic [1:0]   code,
   output logic [31:0]  word
);
   logic [31:0] raw;

   assign raw = 32'(win >> off);

   always_comb begin
      word = '0;
      unique case (code)
         2'b00:   word = '0;
         2'b01:   word = {24'd0, raw[7:0]};
         2'b10:   word = {16'd0, raw[15:0]};
         default: word = raw;
      endcase
   end
endmodule

module decomp_frontend #(
   parameter int          HDR_BEATS  = 3,
   parameter logic [31:0] LAST_TKEEP = 32'h0000_0FFF
) (
   input  logic              aclk,
   input  logic              areset,
   decomp_frontend_if.slave  s_axis,
   decomp_frontend_if.master m_axis,
   output logic              is_comp_reg
);
   localparam int BUF_W = 528;
   localparam int HC_W  = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

   typedef enum logic [2:0] {IDLE, BYPASS, HEADER, FILL, DECODE, EMIT} state_t;

   state_t            state, state_nx;
   logic [BUF_W-1:0]  bit_buf, buf_sh;
   logic [9:0]        fill, rem;
   logic              last_seen;
   logic [HC_W-1:0]   hdr_cnt;

   logic [255:0]      out_data;
   logic [31:0]       out_keep;
   logic              out_valid, out_last;

   logic              s_ready, s_hs, out_free, comp0;
   logic [7:0][8:0]   off;
   logic [8:0]        glen, nxt_len;
   logic              grp_ok, is_last;
   logic [7:0][31:0]  words;

   function automatic logic [8:0] code_len(input logic [1:0] c);
      case (c)
         2'b00:   return 9'd0;
         2'b01:   return 9'd8;
         2'b10:   return 9'd16;
         default: return 9'd32;
      endcase
   endfunction

   function automatic logic [8:0] group_len(input logic [15:0] bm);
      logic [8:0] l;
      l = 9'd16;
      for (int i = 0; i < 8; i++) l = l + code_len(bm[2*i +: 2]);
      return l;
   endfunction

   assign s_hs     = s_axis.tvalid && s_ready;
   assign out_free = !out_valid || m_axis.tready;
   assign comp0    = (s_axis.tdata[191:184] == 8'h06) && (s_axis.tdata[127:120] != 8'h00);

   // Prefix sums of the field lengths give each word's bit offset inside the group.
   always_comb begin
      logic [8:0] acc;
      acc = 9'd16;
      off = '0;
      for (int i = 0; i < 8; i++) begin
         off[i] = acc;
         acc    = acc + code_len(bit_buf[2*i +: 2]);
      end
      glen = acc;
   end

   assign grp_ok  = (fill >= 10'd16) && (fill >= {1'b0, glen});
   assign buf_sh  = bit_buf >> glen;
   assign rem     = fill - {1'b0, glen};
   assign nxt_len = group_len(buf_sh[15:0]);
   // Trailing bits that cannot form a whole group are encoder padding.
   assign is_last = last_seen && ((rem < 10'd16) || (rem < {1'b0, nxt_len}));

   for (genvar g = 0; g < 8; g++) begin : g_lane
      decomp_lane u_lane (
         .win  (bit_buf[271:0]),
         .off  (off[g]),
         .code (bit_buf[2*g +: 2]),
         .word (words[g])
      );
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (s_hs) begin
            if (s_axis.tlast) state_nx = IDLE;
            else if (comp0)   state_nx = (HDR_BEATS == 0) ? FILL : HEADER;
            else              state_nx = BYPASS;
         end
         BYPASS: if (s_hs && s_axis.tlast) state_nx = IDLE;
         HEADER: if (s_hs) begin
            if (s_axis.tlast)                          state_nx = IDLE;
            else if (hdr_cnt == HC_W'(HDR_BEATS - 1))  state_nx = FILL;
         end
         FILL: begin
            if (grp_ok) begin
               if (out_free) state_nx = DECODE;
            end else if (last_seen) begin
               state_nx = IDLE;
            end
         end
         DECODE: state_nx = EMIT;
         EMIT: if (m_axis.tready) begin
            if (out_last)    state_nx = IDLE;
            else if (grp_ok) state_nx = DECODE;
            else             state_nx = FILL;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Payload input is held off while a complete group waits, so the buffer never shifts and fills at once.
   always_comb begin
      s_ready = 1'b0;
      unique case (state)
         IDLE, BYPASS, HEADER: s_ready = out_free;
         FILL:                 s_ready = !last_seen && !grp_ok && (fill <= 10'd272);
         default:              s_ready = 1'b0;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         out_data    <= '0;
         out_keep    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         bit_buf     <= '0;
         fill        <= '0;
         last_seen   <= 1'b0;
         hdr_cnt     <= '0;
         is_comp_reg <= 1'b0;
      end else begin
         if (s_hs && state != FILL) begin
            out_data  <= s_axis.tdata;
            out_keep  <= s_axis.tkeep;
            out_last  <= s_axis.tlast;
            out_valid <= 1'b1;
         end else if (state == DECODE) begin
            out_data  <= words;
            out_keep  <= is_last ? LAST_TKEEP : 32'hFFFF_FFFF;
            out_last  <= is_last;
            out_valid <= 1'b1;
         end else if (m_axis.tready) begin
            out_valid <= 1'b0;
         end

         if (state != IDLE && state_nx == IDLE) begin
            bit_buf     <= '0;
            fill        <= '0;
            last_seen   <= 1'b0;
            is_comp_reg <= 1'b0;
         end else if (state == IDLE && s_hs) begin
            is_comp_reg <= comp0 && !s_axis.tlast;
            hdr_cnt     <= '0;
         end else if (state == HEADER && s_hs) begin
            hdr_cnt <= hdr_cnt + 1'b1;
         end else if (state == FILL && s_hs) begin
            bit_buf <= bit_buf | (BUF_W'(s_axis.tdata) << fill);
            fill    <= fill + 10'd256;
            if (s_axis.tlast) last_seen <= 1'b1;
         end else if (state == DECODE) begin
            bit_buf <= buf_sh;
            fill    <= rem;
         end
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tdata  = out_data;
   assign m_axis.tkeep  = out_keep;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_last;
endmodule

// File: tb/tb_decomp_frontend.sv
// Directed bench for decomp_frontend: bypass, header, decompression, backpressure and reset cases.
module tb_decomp_frontend;
   localparam logic [31:0] LAST_TKEEP = 32'h0000_0FFF;

   logic aclk = 1'b0;
   logic areset;
   logic is_comp_reg;

   decomp_frontend_if s_axis ();
   decomp_frontend_if m_axis ();

   decomp_frontend #(.HDR_BEATS(3), .LAST_TKEEP(LAST_TKEEP)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_axis      (s_axis),
      .m_axis      (m_axis),
      .is_comp_reg (is_comp_reg)
   );

   always #5 aclk = ~aclk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // input beats to drive, expected output beats, observed output beats
   logic [255:0] in_d[$];  logic [31:0] in_k[$];  logic in_l[$];
   logic [255:0] ex_d[$];  logic [31:0] ex_k[$];  logic ex_l[$];
   logic [255:0] ob_d[$];  logic [31:0] ob_k[$];  logic ob_l[$];

   bit           rdy_tgl = 1'b0;
   bit           stalled = 1'b0;
   logic [255:0] hold_d;
   logic [33:0]  hold_c;
   logic [7:0]   pkt_id = 8'd0;

   // Output side: drive tready, record handshakes, check stability across stalls.
   initial begin
      m_axis.tready = 1'b1;
      forever begin
         @(negedge aclk);
         if (stalled) begin
            chk("stall_data", m_axis.tdata, hold_d);
            chk("stall_ctl", 256'({m_axis.tvalid, m_axis.tlast, m_axis.tkeep}), 256'(hold_c));
         end
         m_axis.tready = rdy_tgl ? ~m_axis.tready : 1'b1;
         stalled = m_axis.tvalid && !m_axis.tready;
         hold_d  = m_axis.tdata;
         hold_c  = {m_axis.tvalid, m_axis.tlast, m_axis.tkeep};
         if (m_axis.tvalid && m_axis.tready) begin
            ob_d.push_back(m_axis.tdata);
            ob_k.push_back(m_axis.tkeep);
            ob_l.push_back(m_axis.tlast);
         end
      end
   end

   task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
      int n = 0;
      @(negedge aclk);
      s_axis.tdata  = d;
      s_axis.tkeep  = k;
      s_axis.tlast  = l;
      s_axis.tvalid = 1'b1;
      #1;
      while (!s_axis.tready && n < 500) begin
         @(negedge aclk);
         #1;
         n++;
      end
      if (!s_axis.tready) begin
         chk("in_ready_timeout", 256'(s_axis.tready), 256'd1);
         s_axis.tvalid = 1'b0;
         return;
      end
      @(posedge aclk);
   endtask

   task automatic send_all(input logic exp_comp, input string tag);
      for (int b = 0; b < in_d.size(); b++) begin
         send_beat(in_d[b], in_k[b], in_l[b]);
         if (b == 0) begin
            #1;
            chk({tag, "_is_comp"}, 256'(is_comp_reg), 256'(exp_comp));
         end
      end
      @(negedge aclk);
      s_axis.tvalid = 1'b0;
      in_d.delete(); in_k.delete(); in_l.delete();
   endtask

   task automatic check_out(input string tag);
      int n = 0;
      while (ob_d.size() < ex_d.size() && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      repeat (8) @(negedge aclk);
      chk({tag, "_count"}, 256'(ob_d.size()), 256'(ex_d.size()));
      for (int i = 0; i < ex_d.size() && i < ob_d.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), ob_d[i], ex_d[i]);
         chk($sformatf("%s_keep%0d", tag, i), 256'(ob_k[i]), 256'(ex_k[i]));
         chk($sformatf("%s_last%0d", tag, i), 256'(ob_l[i]), 256'(ex_l[i]));
      end
      ex_d.delete(); ex_k.delete(); ex_l.delete();
      ob_d.delete(); ob_k.delete(); ob_l.delete();
   endtask

   task automatic run_pkt(input logic exp_comp, input string tag);
      send_all(exp_comp, tag);
      check_out(tag);
      chk({tag, "_is_comp_end"}, 256'(is_comp_reg), 256'd0);
   endtask

   // Beats forwarded verbatim (bypass packets and compressed-packet headers).
   task automatic pass_beats(input logic [7:0] proto, input logic [7:0] tos, input int nb, input logic lst);
      logic [255:0] d;
      logic [31:0]  k;
      logic         l;
      pkt_id++;
      for (int b = 0; b < nb; b++) begin
         d = {8{8'hC0, pkt_id, 8'(b), 8'h5A}};
         if (b == 0) begin
            d[191:184] = proto;
            d[127:120] = tos;
         end
         l = lst && (b == nb - 1);
         k = l ? 32'h0000_00FF : 32'hFFFF_FFFF;
         in_d.push_back(d); in_k.push_back(k); in_l.push_back(l);
         ex_d.push_back(d); ex_k.push_back(k); ex_l.push_back(l);
      end
   endtask

   logic [4095:0] stream = '0;
   int            spos   = 0;

   task automatic enc_put(input logic [31:0] v, input int n);
      for (int k = 0; k < n; k++) stream[spos + k] = v[k];
      spos += n;
   endtask

   task automatic enc_group(input logic [15:0] bm, input logic [7:0][31:0] v);
      logic [255:0] w;
      w = '0;
      enc_put(32'(bm), 16);
      for (int i = 0; i < 8; i++) begin
         case (bm[2*i +: 2])
            2'b00: w[32*i +: 32] = 32'd0;
            2'b01: begin enc_put(v[i], 8);  w[32*i +: 32] = {24'd0, v[i][7:0]};  end
            2'b10: begin enc_put(v[i], 16); w[32*i +: 32] = {16'd0, v[i][15:0]}; end
            default: begin enc_put(v[i], 32); w[32*i +: 32] = v[i]; end
         endcase
      end
      ex_d.push_back(w); ex_k.push_back(32'hFFFF_FFFF); ex_l.push_back(1'b0);
   endtask

   // Pad with ones (never a complete group) and split into payload beats.
   task automatic enc_finish;
      int nb;
      while (spos % 256 != 0) begin
         stream[spos] = 1'b1;
         spos++;
      end
      nb = spos / 256;
      for (int b = 0; b < nb; b++) begin
         in_d.push_back(stream[b*256 +: 256]);
         in_k.push_back(32'hFFFF_FFFF);
         in_l.push_back(b == nb - 1);
      end
      ex_l[ex_l.size() - 1] = 1'b1;
      ex_k[ex_k.size() - 1] = LAST_TKEEP;
      stream = '0;
      spos   = 0;
   endtask

   initial begin
      logic [7:0][31:0] v;
      logic [15:0]      bm;
      areset        = 1'b1;
      s_axis.tdata  = '0;
      s_axis.tkeep  = '0;
      s_axis.tlast  = 1'b0;
      s_axis.tvalid = 1'b0;
      repeat (3) @(negedge aclk);
      areset = 1'b0;
      #1;
      chk("rst_s_tready", 256'(s_axis.tready), 256'd1);
      chk("rst_m_tvalid", 256'(m_axis.tvalid), 256'd0);
      chk("rst_m_tlast",  256'(m_axis.tlast),  256'd0);
      chk("rst_m_tdata",  m_axis.tdata, 256'd0);
      chk("rst_is_comp",  256'(is_comp_reg), 256'd0);

      // UDP packet passes through unchanged
      pass_beats(8'h11, 8'h20, 4, 1'b1);
      run_pkt(1'b0, "udp_bypass");

      // TCP with ToS 0 is not compressed
      pass_beats(8'h06, 8'h00, 2, 1'b1);
      run_pkt(1'b0, "tos0_bypass");

      // compressed marking but packet ends inside the header: zero groups
      pass_beats(8'h06, 8'h05, 3, 1'b1);
      run_pkt(1'b1, "zero_groups");

      // one raw group, words 0..7
      pass_beats(8'h06, 8'h01, 4, 1'b0);
      v = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
      enc_group(16'hFFFF, v);
      enc_finish();
      run_pkt(1'b1, "raw_group");

      // empty group then byte-coded group 01..08
      pass_beats(8'h06, 8'h02, 4, 1'b0);
      enc_group(16'h0000, '0);
      v = {32'h08, 32'h07, 32'h06, 32'h05, 32'h04, 32'h03, 32'h02, 32'h01};
      enc_group(16'h5555, v);
      enc_finish();
      run_pkt(1'b1, "zero_then_bytes");

      // mixed codes, second group straddles the input beat boundary
      pass_beats(8'h06, 8'h03, 4, 1'b0);
      v = {32'h0000_1234, 32'h0000_007F, 32'h0000_CAFE, 32'h1234_5678,
           32'hDEAD_BEEF, 32'h0000_BEEF, 32'h0000_005A, 32'hFFFF_FFFF};
      enc_group(16'h1BE4, v);
      for (int i = 0; i < 8; i++) v[i] = 32'hA000_0000 + 32'(i);
      enc_group(16'hFFFF, v);
      enc_finish();
      run_pkt(1'b1, "mixed_span");

      // ten groups with tready toggling every cycle
      rdy_tgl = 1'b1;
      pass_beats(8'h06, 8'h04, 4, 1'b0);
      for (int g = 0; g < 10; g++) begin
         bm = '0;
         for (int i = 0; i < 8; i++) begin
            bm[2*i +: 2] = 2'((g * 7 + i * i) % 4);
            v[i] = 32'h9E37_79B9 * 32'(g * 8 + i + 1);
         end
         enc_group(bm, v);
      end
      enc_finish();
      run_pkt(1'b1, "backpressure");
      rdy_tgl = 1'b0;

      // reset in the middle of a compressed payload
      pass_beats(8'h06, 8'h09, 4, 1'b0);
      in_d.push_back({240'd0, 16'hFFFF}); in_k.push_back(32'hFFFF_FFFF); in_l.push_back(1'b0);
      send_all(1'b1, "mid_rst");
      check_out("mid_rst_hdr");
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      #1;
      chk("mid_rst_m_tvalid", 256'(m_axis.tvalid), 256'd0);
      chk("mid_rst_m_tlast",  256'(m_axis.tlast),  256'd0);
      chk("mid_rst_s_tready", 256'(s_axis.tready), 256'd1);
      chk("mid_rst_is_comp",  256'(is_comp_reg),   256'd0);
      areset = 1'b0;
      pass_beats(8'h11, 8'h00, 2, 1'b1);
      run_pkt(1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
